// File: rtl/fp_stream_accumulator_if.sv
// Sample-in / result-out bundle for fp_stream_accumulator; "slave" is the accumulator side.
// Producer/consumer logic uses the "master" modport.
interface fp_stream_accumulator_if #(
    parameter int COUNT_W = 16
) ();
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic [COUNT_W-1:0] out_count;
    logic [4:0]         status;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, status
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, status
    );
endinterface

// File: rtl/fp_stream_accumulator.sv
// FP32 burst summer, one sample per cycle, ADD_LATENCY interleaved partial sums; result <= L*(clog2 L+2)+2 cycles after last beat.
// in_ready low while draining or holding a result (held until out_ready); `define FP_ACC_EXC_EN adds the Inf/NaN flag in status[3].
module fp_stream_accumulator #(
    parameter int ADD_LATENCY = 7,
    parameter int COUNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    fp_stream_accumulator_if.slave  bus
);
    localparam int LCW = $clog2(ADD_LATENCY + 1) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADD_LATENCY-1:0] r_tag;
    logic [LCW-1:0]       r_live_cnt;
    logic [31:0]          r_hold;
    logic                 r_hold_vld;
    logic [COUNT_W-1:0]   r_count;
    logic [COUNT_W-1:0]   w_count_inc;
    logic                 r_sat;
    logic [31:0]          r_out_data;
    logic [COUNT_W-1:0]   r_out_count;
    logic                 w_exc;

    logic [31:0] w_sum;
    logic [31:0] w_add_a;
    logic [31:0] w_add_b;
    logic        w_out_live;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_handshake;
    logic        w_tag_in;
    logic        w_hold_load;
    logic        w_merge;
    logic        w_finish;

    assign w_out_live  = r_tag[ADD_LATENCY-1];
    assign w_in_ready  = (r_state == ST_ACCUM);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_handshake = (r_state == ST_DONE) && bus.out_ready;
    assign w_count_inc = (&r_count) ? r_count : r_count + COUNT_W'(1);

    fp_acc_add_pipe #(.LATENCY(ADD_LATENCY)) u_add (
        .clk   (clk),
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_add_a     = 32'd0;
        w_add_b     = 32'd0;
        w_tag_in    = 1'b0;
        w_hold_load = 1'b0;
        w_merge     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_ACCUM;
            ST_ACCUM: begin
                // Every slot keeps circulating; an empty cycle adds +0.0 to a live slot.
                w_add_a  = w_accept ? bus.in_data : 32'd0;
                w_add_b  = w_out_live ? w_sum : 32'd0;
                w_tag_in = w_accept || w_out_live;
                if (w_accept && bus.in_last) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_hold_vld && r_live_cnt == LCW'(1)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_out_live) begin
                    if (r_hold_vld) begin
                        w_merge  = 1'b1;
                        w_add_a  = r_hold;
                        w_add_b  = w_sum;
                        w_tag_in = 1'b1;
                    end else begin
                        w_hold_load = 1'b1;
                    end
                end
            end
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag       <= '0;
            r_live_cnt  <= '0;
            r_hold      <= '0;
            r_hold_vld  <= 1'b0;
            r_count     <= '0;
            r_sat       <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else begin
            r_tag <= {r_tag[ADD_LATENCY-2:0], w_tag_in};
            // live_cnt = live values in the pipe plus the hold register
            if (w_accept && !w_out_live) r_live_cnt <= r_live_cnt + LCW'(1);
            else if (w_merge)            r_live_cnt <= r_live_cnt - LCW'(1);
            else if (w_finish)           r_live_cnt <= '0;
            if (w_hold_load) begin
                r_hold     <= w_sum;
                r_hold_vld <= 1'b1;
            end else if (w_merge || w_finish) begin
                r_hold_vld <= 1'b0;
            end
            if (w_finish) begin
                r_out_data  <= r_hold;
                r_out_count <= r_count;
            end
            if (w_handshake) begin
                r_count <= '0;
                r_sat   <= 1'b0;
            end else if (w_accept) begin
                r_count <= w_count_inc;
                if (&w_count_inc) r_sat <= 1'b1;
            end
        end
    end

`ifdef FP_ACC_EXC_EN
    logic r_exc;
    always_ff @(posedge clk) begin
        if (reset || w_handshake)                          r_exc <= 1'b0;
        else if (w_accept && bus.in_data[30:23] == 8'hFF)  r_exc <= 1'b1;
        else if (w_finish && r_hold[30:23] == 8'hFF)       r_exc <= 1'b1;
    end
    assign w_exc = r_exc;
`else
    assign w_exc = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;
    assign bus.status    = {1'b0, w_exc, r_sat, r_state};
endmodule

// Pipelined IEEE-754 single add, round-to-nearest-even, LATENCY register stages, no reset.
// Same timing contract as the altfp_add core it stands in for.
module fp_acc_add_pipe #(
    parameter int LATENCY = 7
) (
    input  logic        clk,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, r;
        logic [7:0]  ex, ey, d;
        logic [26:0] mx, my, mask;
        logic [27:0] s;
        logic [8:0]  e;
        logic [24:0] rm;
        logic        rnd;
        r = 32'd0;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0) ||
                (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]))
                r = 32'h7FC0_0000;
            else
                r = (a[30:23] == 8'hFF) ? a : b;
        end else begin
            if (a[30:0] >= b[30:0]) begin x = a; y = b; end
            else                    begin x = b; y = a; end
            ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
            ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
            mx = {(x[30:23] != 8'd0), x[22:0], 3'b000};
            my = {(y[30:23] != 8'd0), y[22:0], 3'b000};
            d  = ex - ey;
            // Align the smaller operand, folding shifted-out bits into the sticky bit.
            if (d >= 8'd27) begin
                my = {26'd0, |my};
            end else begin
                mask = (27'd1 << d) - 27'd1;
                my   = (my >> d) | {26'd0, |(my & mask)};
            end
            e = {1'b0, ex};
            if (x[31] == y[31]) begin
                s = {1'b0, mx} + {1'b0, my};
                if (s[27]) begin
                    s = {1'b0, s[27:2], s[1] | s[0]};
                    e = e + 9'd1;
                end
            end else begin
                s = {1'b0, mx} - {1'b0, my};
                for (int i = 0; i < 26; i++) begin
                    if (!s[26] && e > 9'd1) begin
                        s = s << 1;
                        e = e - 9'd1;
                    end
                end
            end
            if (s == 28'd0) begin
                r = (x[31] == y[31]) ? {x[31], 31'd0} : 32'd0;
            end else begin
                rnd = s[2] & (s[1] | s[0] | s[3]);
                rm  = {1'b0, s[26:3]} + {24'd0, rnd};
                if (rm[24]) begin
                    rm = rm >> 1;
                    e  = e + 9'd1;
                end
                if (e >= 9'd255)  r = {x[31], 8'hFF, 23'd0};
                else if (!rm[23]) r = {x[31], 8'h00, rm[22:0]};
                else              r = {x[31], e[7:0], rm[22:0]};
            end
        end
        return r;
    endfunction

    logic [31:0] r_stage [LATENCY];

    always_ff @(posedge clk) begin
        r_stage[0] <= fp_add(i_a, i_b);
        for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
    end

    assign o_sum = r_stage[LATENCY-1];
endmodule
